// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared mode codes, FSM encoding and width helper for the Sobel stream filter
package sobel_pkg;

  localparam logic [1:0] MODE_GX  = 2'b00;
  localparam logic [1:0] MODE_GY  = 2'b01;
  localparam logic [1:0] MODE_ABS = 2'b10;
  localparam logic [1:0] MODE_SAT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Gradient magnitude reaches 4*(2^pix_w-1) in either sign, plus the sign bit.
  function automatic int out_width(input int pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - column-addressed ring holding the two previous lines packed per entry
module sobel_line_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 5,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read is combinational so the old entry is seen in the same cycle it is overwritten.
  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel filter: counters, FSM, window, two-stage arithmetic
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 5,
  parameter int IMG_H = 5,
  parameter int OUT_W = out_width(PIX_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic             busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
  localparam logic [OUT_W-1:0] SAT_MAX  = OUT_W'((1 << PIX_W) - 1);

  state_t                    state;
  logic [1:0]                mode_q;
  logic [CW-1:0]             col;
  logic [RW-1:0]             row;
  logic                      en;
  logic                      accept;
  logic                      emit;
  logic                      frame_end;
  logic [2*PIX_W-1:0]        lb_rd;
  logic [2*PIX_W-1:0]        lb_wr;
  logic [PIX_W-1:0]          win [3][3];
  logic [PIX_W-1:0]          nxt [3][3];
  logic signed [OUT_W-1:0]   gx_c;
  logic signed [OUT_W-1:0]   gy_c;
  logic signed [OUT_W-1:0]   gx1;
  logic signed [OUT_W-1:0]   gy1;
  logic                      v1;
  logic                      last1;
  logic [OUT_W-1:0]          abs_x;
  logic [OUT_W-1:0]          abs_y;
  logic [OUT_W-1:0]          abs_sum;
  logic [OUT_W-1:0]          sel;

  assign en        = !m_valid || m_ready;
  assign s_ready   = en && (state != ST_DRAIN);
  assign accept    = s_valid && s_ready;
  assign emit      = (row >= RW'(2)) && (col >= CW'(2));
  assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

  // Each entry is {line r-2, line r-1}; on write the r-1 half ages into the r-2 slot.
  assign lb_wr = {lb_rd[PIX_W-1:0], s_data};

  sobel_line_buffer #(
    .WIDTH (2 * PIX_W),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_line_buffer (
    .clk     (clk),
    .we      (accept),
    .addr    (col),
    .wr_data (lb_wr),
    .rd_data (lb_rd)
  );

  function automatic logic signed [OUT_W-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{(OUT_W - PIX_W){1'b0}}, p});
  endfunction

  // Next window = current window shifted left with the incoming column on the right.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nxt[i][0] = win[i][1];
      nxt[i][1] = win[i][2];
    end
    nxt[0][2] = lb_rd[2*PIX_W-1:PIX_W];
    nxt[1][2] = lb_rd[PIX_W-1:0];
    nxt[2][2] = s_data;
  end

  // Kernel is evaluated on the next window so stage 1 loads on the accepting edge.
  always_comb begin
    gx_c = (ext(nxt[0][2]) + (ext(nxt[1][2]) <<< 1) + ext(nxt[2][2]))
         - (ext(nxt[0][0]) + (ext(nxt[1][0]) <<< 1) + ext(nxt[2][0]));
    gy_c = (ext(nxt[0][0]) + (ext(nxt[0][1]) <<< 1) + ext(nxt[0][2]))
         - (ext(nxt[2][0]) + (ext(nxt[2][1]) <<< 1) + ext(nxt[2][2]));
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win[i][j] <= nxt[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      gx1   <= '0;
      gy1   <= '0;
    end else if (en) begin
      v1    <= accept && emit;
      last1 <= accept && emit && frame_end;
      gx1   <= gx_c;
      gy1   <= gy_c;
    end
  end

  always_comb begin
    abs_x   = gx1[OUT_W-1] ? $unsigned(-gx1) : $unsigned(gx1);
    abs_y   = gy1[OUT_W-1] ? $unsigned(-gy1) : $unsigned(gy1);
    abs_sum = abs_x + abs_y;
    case (mode_q)
      MODE_GX:  sel = $unsigned(gx1);
      MODE_GY:  sel = $unsigned(gy1);
      MODE_ABS: sel = abs_sum;
      default:  sel = (abs_sum > SAT_MAX) ? SAT_MAX : abs_sum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (en) begin
      m_valid <= v1;
      m_last  <= last1;
      m_data  <= sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      col    <= '0;
      row    <= '0;
      busy   <= 1'b0;
      mode_q <= MODE_GX;
    end else begin
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_RUN;
            mode_q <= mode;
            busy   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept && frame_end) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (m_valid && m_ready && m_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - directed self-checking bench for sobel_stream (5x5 and 7x4 instances)
module tb_sobel_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        m_ready = 1'b1;
  logic        sel7 = 1'b0;

  logic        s_valid5, s_ready5, m_valid5, m_last5, busy5;
  logic        s_valid7, s_ready7, m_valid7, m_last7, busy7;
  logic [10:0] m_data5, m_data7;
  logic        o_s_ready, o_m_valid, o_m_last, o_busy;
  logic [10:0] o_m_data;

  int checks = 0;
  int failures = 0;
  int pix [64];
  int got [$];
  int gotl [$];
  int expq [$];

  always #5 clk = ~clk;

  assign s_valid5  = s_valid && !sel7;
  assign s_valid7  = s_valid && sel7;
  assign o_s_ready = sel7 ? s_ready7 : s_ready5;
  assign o_m_valid = sel7 ? m_valid7 : m_valid5;
  assign o_m_last  = sel7 ? m_last7  : m_last5;
  assign o_busy    = sel7 ? busy7    : busy5;
  assign o_m_data  = sel7 ? m_data7  : m_data5;

  sobel_stream #(.PIX_W(8), .IMG_W(5), .IMG_H(5)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data),
    .m_valid(m_valid5), .m_ready(m_ready), .m_data(m_data5),
    .m_last(m_last5), .busy(busy5)
  );

  sobel_stream #(.PIX_W(8), .IMG_W(7), .IMG_H(4)) dut7 (
    .clk(clk), .rst(rst), .mode(mode),
    .s_valid(s_valid7), .s_ready(s_ready7), .s_data(s_data),
    .m_valid(m_valid7), .m_ready(m_ready), .m_data(m_data7),
    .m_last(m_last7), .busy(busy7)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic set_image(input int kind, input int w, input int h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        pix[r*w+c] = (kind == 0) ? 100 : (kind == 1) ? 10 * c : ((r < 2) ? 0 : 255);
      end
    end
  endtask

  task automatic build_exp(input int w, input int h, input int md);
    expq.delete();
    for (int r = 1; r <= h - 2; r++) begin
      for (int c = 1; c <= w - 2; c++) begin
        int p [3][3];
        int gx, gy, a;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            p[i][j] = pix[(r-1+i)*w + (c-1+j)];
        gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy = (p[0][0] + 2*p[0][1] + p[0][2]) - (p[2][0] + 2*p[2][1] + p[2][2]);
        a  = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
        case (md)
          0: expq.push_back(gx);
          1: expq.push_back(gy);
          2: expq.push_back(a);
          default: expq.push_back((a > 255) ? 255 : a);
        endcase
      end
    end
  endtask

  function automatic logic ready_at(input int cyc, input int pat);
    logic [4:0] p;
    p = 5'b01001;
    if (pat == 0) return 1'b1;
    if (cyc >= 30 && cyc < 36) return 1'b0;
    return p[cyc % 5];
  endfunction

  task automatic run_frame(input string tag, input int w, input int h, input int md,
                           input int ready_pat, input int toggle_at);
    int npix, nres, idx, cyc, acc_cyc, val_cyc, nlast, held_data;
    logic held;
    npix = w * h;
    nres = (w - 2) * (h - 2);
    idx = 0; cyc = 0; acc_cyc = -1; val_cyc = -1; nlast = 0; held = 1'b0; held_data = 0;
    got.delete();
    gotl.delete();
    sel7 = (w == 7);
    build_exp(w, h, md);
    while ((idx < npix || got.size() < nres) && cyc < 2000) begin
      s_valid = (idx < npix);
      s_data  = 8'(pix[(idx < npix) ? idx : 0]);
      mode    = (toggle_at >= 0 && idx >= toggle_at) ? 2'(md ^ 1) : 2'(md);
      m_ready = ready_at(cyc, ready_pat);
      @(negedge clk);
      if (held) begin
        chk({tag, " hold_valid"}, int'(o_m_valid), 1);
        chk({tag, " hold_data"}, int'(o_m_data), held_data);
      end
      if (o_m_valid && !m_ready) begin
        chk({tag, " s_ready_stall"}, int'(o_s_ready), 0);
        held = 1'b1;
        held_data = int'(o_m_data);
      end else begin
        held = 1'b0;
      end
      if (s_valid && o_s_ready) begin
        if (idx == 2 * w + 2) acc_cyc = cyc;
        idx++;
      end
      if (o_m_valid && val_cyc < 0) val_cyc = cyc;
      if (o_m_valid && m_ready) begin
        got.push_back((md < 2) ? int'($signed(o_m_data)) : int'(o_m_data));
        gotl.push_back(int'(o_m_last));
        nlast += int'(o_m_last);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk({tag, " timeout"}, int'(cyc < 2000), 1);
    chk({tag, " count"}, got.size(), nres);
    chk({tag, " busy_end"}, int'(o_busy), 0);
    chk({tag, " last_count"}, nlast, 1);
    for (int k = 0; k < got.size() && k < nres; k++) begin
      chk($sformatf("%s data[%0d]", tag, k), got[k], expq[k]);
      chk($sformatf("%s last[%0d]", tag, k), gotl[k], int'(k == nres - 1));
    end
    if (ready_pat == 0) chk({tag, " latency"}, val_cyc - acc_cyc, 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({tag, " no_extra"}, int'(o_m_valid), 0);
      chk({tag, " idle_ready"}, int'(o_s_ready), 1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset s_ready", int'(s_ready5), 1);
    chk("reset m_valid", int'(m_valid5), 0);
    chk("reset m_last", int'(m_last5), 0);
    chk("reset busy", int'(busy5), 0);
    chk("reset m_data", int'(m_data5), 0);
    chk("reset m_valid7", int'(m_valid7), 0);
    @(posedge clk);
    #1;

    // 1: flat image gives zero gradient
    set_image(0, 5, 5);
    run_frame("t1", 5, 5, 0, 0, -1);
    chk("t1 hand0", got[0], 0);

    // 2: horizontal ramp, Gx = 4*20 = 80, Gy = 0
    set_image(1, 5, 5);
    run_frame("t2gx", 5, 5, 0, 0, -1);
    chk("t2gx hand4", got[4], 80);
    run_frame("t2gy", 5, 5, 1, 0, -1);
    chk("t2gy hand8", got[8], 0);

    // 3: horizontal step between rows 1 and 2
    set_image(2, 5, 5);
    run_frame("t3gy", 5, 5, 1, 0, -1);
    chk("t3gy hand0", got[0], -1020);
    chk("t3gy hand3", got[3], -1020);
    chk("t3gy hand6", got[6], 0);
    run_frame("t3abs", 5, 5, 2, 0, -1);
    chk("t3abs hand3", got[3], 1020);
    run_frame("t3sat", 5, 5, 3, 0, -1);
    chk("t3sat hand0", got[0], 255);
    chk("t3sat hand8", got[8], 0);

    // 4: same frame under sink back-pressure
    run_frame("t4", 5, 5, 2, 1, -1);
    chk("t4 hand5", got[5], 1020);
    chk("t4 hand7", got[7], 0);

    // 5: reset after 12 pixels, then a clean ramp frame
    set_image(1, 5, 5);
    sel7 = 1'b0;
    mode = 2'b00;
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1;
      s_data = 8'(pix[i]);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    chk("t5 busy_mid", int'(busy5), 1);
    rst = 1'b1;
    #2;
    chk("t5 busy_async", int'(busy5), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5 no_stale", int'(m_valid5), 0);
    end
    @(posedge clk);
    #1;
    run_frame("t5", 5, 5, 0, 0, -1);
    chk("t5 hand0", got[0], 80);

    // 6: mode change mid-frame is ignored; next frame takes its own mode
    set_image(1, 5, 5);
    run_frame("t6f1", 5, 5, 0, 0, 12);
    chk("t6f1 hand8", got[8], 80);
    set_image(2, 5, 5);
    run_frame("t6f2", 5, 5, 1, 0, -1);
    chk("t6f2 hand2", got[2], -1020);
    set_image(1, 7, 4);
    run_frame("t6w7", 7, 4, 0, 0, -1);
    chk("t6w7 hand9", got[9], 80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
